// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// Optional feature macro: MCU_ILLEGAL_TRAP_EN (adds the TRAP state and trap port).
package mcu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  // Opcode map (low 4 bits of the opcode field)
  localparam logic [3:0] OP_MOVE = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_NOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;

  // ALU control codes
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_NOT  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLL  = 3'b110;
  localparam logic [2:0] ALU_SRL  = 3'b111;

  // PC source select
  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  typedef enum logic [2:0] {
    C_ALU,
    C_J,
    C_JAL,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_RSVD
  } op_class_e;

  // hi_nz flags non-zero opcode bits above bit 3, which make the opcode reserved
  function automatic op_class_e op_class(input logic [3:0] op, input logic hi_nz);
    op_class_e cls;
    if (hi_nz) cls = C_RSVD;
    else if (op[3] == 1'b0) cls = C_ALU;
    else begin
      case (op)
        OP_J:    cls = C_J;
        OP_JAL:  cls = C_JAL;
        OP_LW:   cls = C_LW;
        OP_SW:   cls = C_SW;
        OP_BEQ:  cls = C_BEQ;
        OP_BNE:  cls = C_BNE;
        default: cls = C_RSVD;
      endcase
    end
    return cls;
  endfunction

  // ALU opcodes map one-to-one onto the ALU control codes
  function automatic logic [2:0] alu_code(input logic [3:0] op, input op_class_e cls);
    logic [2:0] code;
    case (cls)
      C_ALU:        code = op[2:0];
      C_LW, C_SW:   code = ALU_ADD;
      C_BEQ, C_BNE: code = ALU_SUB;
      default:      code = ALU_PASS;
    endcase
    return code;
  endfunction

  function automatic logic alu_imm(input logic [3:0] op, input op_class_e cls);
    logic imm;
    case (cls)
      C_ALU:      imm = (op == OP_SLL) || (op == OP_SRL);
      C_LW, C_SW: imm = 1'b1;
      default:    imm = 1'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction/data memory handshake bundle for the multi-cycle control unit.
interface multicycle_control_unit_if #(
  parameter int INSTR_W = 8
) ();
  logic [INSTR_W-1:0] instr;
  logic               imem_req;
  logic               imem_ready;
  logic               dmem_req;
  logic               dmem_ready;
  logic               wren_data;

  modport master (
    output imem_req, dmem_req, wren_data,
    input  instr, imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, wren_data,
    output instr, imem_ready, dmem_ready
  );
endinterface

// File: rtl/mcu_retire_counter.sv
// Saturating retired-instruction counter.
module mcu_retire_counter #(
  parameter int RET_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [RET_CNT_W-1:0] count
);

  // Count retirements, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// handshakes, branch resolution and a retired-instruction counter.
// Optional feature macro: MCU_ILLEGAL_TRAP_EN (reserved opcode traps instead of NOP).
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int INSTR_W    = 8,
  parameter int OP_W       = 4,
  parameter int ALU_CTRL_W = 3,
  parameter int RET_CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  multicycle_control_unit_if.master    mem,
  input  logic                         alu_zero,
  output logic                         ir_load,
  output logic [ALU_CTRL_W-1:0]        alu_control,
  output logic                         alu_src,
  output logic                         wren_reg,
  output logic                         datamem_toreg,
  output logic                         pc_en,
  output logic [1:0]                   pc_src,
  output logic                         link,
  output logic [RET_CNT_W-1:0]         instr_retired
`ifdef MCU_ILLEGAL_TRAP_EN
  ,
  output logic                         trap
`endif
);

  state_e          state, state_n;
  logic [OP_W-1:0] opcode_q;
  logic [OP_W-1:0] op_hi;
  op_class_e       cls;
  logic            fetch_done;
  logic            retire;
  logic [2:0]      alu_ctl;
  logic            imem_req_c, dmem_req_c, wren_data_c;
  logic            taken;

  assign fetch_done = (state == S_FETCH) && run && mem.imem_ready;
  assign op_hi      = opcode_q >> 4;
  assign cls        = op_class(opcode_q[3:0], |op_hi);
  assign taken      = ((cls == C_BEQ) && alu_zero) || ((cls == C_BNE) && !alu_zero);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_n;
  end

  // Opcode latch, loaded together with the instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          opcode_q <= '0;
    else if (fetch_done) opcode_q <= mem.instr[INSTR_W-1 -: OP_W];
  end

  // Next-state and strobe decode; everything is forced low while rst_n is
  // asserted so the outputs clear asynchronously with the state register
  always_comb begin
    state_n       = state;
    ir_load       = 1'b0;
    alu_ctl       = ALU_PASS;
    alu_src       = 1'b0;
    wren_reg      = 1'b0;
    datamem_toreg = 1'b0;
    pc_en         = 1'b0;
    pc_src        = PC_NEXT;
    link          = 1'b0;
    imem_req_c    = 1'b0;
    dmem_req_c    = 1'b0;
    wren_data_c   = 1'b0;
`ifdef MCU_ILLEGAL_TRAP_EN
    trap          = 1'b0;
`endif
    if (rst_n) begin
      if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        alu_ctl = alu_code(opcode_q[3:0], cls);
        alu_src = alu_imm(opcode_q[3:0], cls);
      end
      unique case (state)
        S_FETCH: begin
          if (run) begin
            imem_req_c = 1'b1;
            if (mem.imem_ready) begin
              ir_load = 1'b1;
              state_n = S_DECODE;
            end
          end
        end
        S_DECODE: state_n = S_EXEC;
        S_EXEC: begin
          unique case (cls)
            C_ALU: state_n = S_WB;
            C_J: begin
              pc_en   = 1'b1;
              pc_src  = PC_JUMP;
              state_n = S_FETCH;
            end
            C_JAL: begin
              pc_en    = 1'b1;
              pc_src   = PC_JUMP;
              wren_reg = 1'b1;
              link     = 1'b1;
              state_n  = S_FETCH;
            end
            C_LW, C_SW: state_n = S_MEM;
            C_BEQ, C_BNE: begin
              pc_en   = 1'b1;
              pc_src  = taken ? PC_BRANCH : PC_NEXT;
              state_n = S_FETCH;
            end
            C_RSVD: begin
`ifdef MCU_ILLEGAL_TRAP_EN
              state_n = S_TRAP;
`else
              pc_en   = 1'b1;
              state_n = S_FETCH;
`endif
            end
          endcase
        end
        S_MEM: begin
          dmem_req_c  = 1'b1;
          wren_data_c = (cls == C_SW);
          if (mem.dmem_ready) begin
            if (cls == C_LW) begin
              state_n = S_WB;
            end else begin
              pc_en   = 1'b1;
              state_n = S_FETCH;
            end
          end
        end
        S_WB: begin
          wren_reg      = 1'b1;
          datamem_toreg = (cls == C_LW);
          pc_en         = 1'b1;
          state_n       = S_FETCH;
        end
        S_TRAP: begin
`ifdef MCU_ILLEGAL_TRAP_EN
          trap = 1'b1;
`else
          state_n = S_FETCH;
`endif
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

  assign retire        = (state != S_FETCH) && (state_n == S_FETCH);
  assign alu_control   = ALU_CTRL_W'(alu_ctl);
  assign mem.imem_req  = imem_req_c;
  assign mem.dmem_req  = dmem_req_c;
  assign mem.wren_data = wren_data_c;

  mcu_retire_counter #(
    .RET_CNT_W(RET_CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .count (instr_retired)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        alu_zero = 1'b0;
  logic        ir_load, alu_src, wren_reg, datamem_toreg, pc_en, link;
  logic [2:0]  alu_control;
  logic [1:0]  pc_src;
  logic [15:0] instr_retired;
`ifdef MCU_ILLEGAL_TRAP_EN
  logic        trap;
`endif

  multicycle_control_unit_if #(.INSTR_W(8)) mem_bus ();

  multicycle_control_unit #(
    .INSTR_W(8), .OP_W(4), .ALU_CTRL_W(3), .RET_CNT_W(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .mem           (mem_bus),
    .alu_zero      (alu_zero),
    .ir_load       (ir_load),
    .alu_control   (alu_control),
    .alu_src       (alu_src),
    .wren_reg      (wren_reg),
    .datamem_toreg (datamem_toreg),
    .pc_en         (pc_en),
    .pc_src        (pc_src),
    .link          (link),
    .instr_retired (instr_retired)
`ifdef MCU_ILLEGAL_TRAP_EN
    ,
    .trap          (trap)
`endif
  );

  // Small standalone counter instance to reach saturation quickly
  logic       sat_inc = 1'b0;
  logic [1:0] sat_count;
  mcu_retire_counter #(.RET_CNT_W(2)) sat_cnt (
    .clk(clk), .rst_n(rst_n), .inc(sat_inc), .count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] alu;
    logic       src;
    int         lat;
    logic       wren;
    logic       dtr;
    logic [1:0] pcs;
    logic       lnk;
    int         dmc;
    logic       wd;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] iq[$];
  int         total = 0;
  int         bad = 0;
  int         done = 0;
  int         loads = 0;
  int         imem_wait = 0;
  int         dmem_wait = 0;
  int         exp_ret = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: answers requests after the configured wait cycles
  initial begin
    int iw = 0;
    int dw = 0;
    mem_bus.instr      = '0;
    mem_bus.imem_ready = 1'b0;
    mem_bus.dmem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_bus.imem_req && iq.size() > 0) begin
        if (iw >= imem_wait) begin
          mem_bus.instr      = iq.pop_front();
          mem_bus.imem_ready = 1'b1;
          iw = 0;
        end else begin
          mem_bus.imem_ready = 1'b0;
          iw++;
        end
      end else begin
        mem_bus.imem_ready = 1'b0;
        iw = 0;
      end
      if (mem_bus.dmem_req) begin
        if (dw >= dmem_wait) begin
          mem_bus.dmem_ready = 1'b1;
          dw = 0;
        end else begin
          mem_bus.dmem_ready = 1'b0;
          dw++;
        end
      end else begin
        mem_bus.dmem_ready = 1'b0;
        dw = 0;
      end
    end
  end

  // Monitor: tracks each instruction from ir_load and checks it when pc_en fires
  initial begin
    int         cnt = 0;
    int         dmc = 0;
    logic       wd = 1'b0;
    logic [2:0] cap_alu = '0;
    logic       cap_src = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        cnt = 0; dmc = 0; wd = 1'b0;
      end else begin
        if (ir_load) begin
          cnt = 1; dmc = 0; wd = 1'b0; loads++;
        end else if (cnt != 0) cnt++;
        if (cnt == 2) begin
          cap_alu = alu_control;
          cap_src = alu_src;
        end
        if (mem_bus.dmem_req) begin
          dmc++;
          wd = wd | mem_bus.wren_data;
        end
        if (pc_en) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_pc_en: got 1 expected 0 at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk("alu_control", 32'(cap_alu), 32'(e.alu));
            chk("alu_src", 32'(cap_src), 32'(e.src));
            chk("latency", 32'(cnt), 32'(e.lat));
            chk("wren_reg", 32'(wren_reg), 32'(e.wren));
            chk("datamem_toreg", 32'(datamem_toreg), 32'(e.dtr));
            chk("pc_src", 32'(pc_src), 32'(e.pcs));
            chk("link", 32'(link), 32'(e.lnk));
            chk("dmem_req_cycles", 32'(dmc), 32'(e.dmc));
            chk("wren_data", 32'(wd), 32'(e.wd));
          end
          cnt = 0;
          done++;
        end
      end
    end
  end

  task automatic wait_done(input int target);
    for (int i = 0; i < 80 && done < target; i++) @(posedge clk);
    chk("completion_in_time", 32'(done >= target), 32'd1);
  endtask

  task automatic check_retired();
    @(negedge clk);
    #1;
    chk("instr_retired", 32'(instr_retired), 32'(exp_ret));
  endtask

  task automatic do_instr(input logic [7:0] ins, input int iw, input int dw,
                          input logic z, input exp_t e);
    int target;
    imem_wait = iw;
    dmem_wait = dw;
    alu_zero  = z;
    target    = done + 1;
    sb.push_back(e);
    iq.push_back(ins);
    wait_done(target);
    exp_ret++;
    check_retired();
  endtask

  function automatic exp_t mk(input logic [2:0] alu, input logic src, input int lat,
                              input logic wren, input logic dtr, input logic [1:0] pcs,
                              input logic lnk, input int dmc, input logic wd);
    exp_t e;
    e.alu = alu; e.src = src; e.lat = lat; e.wren = wren; e.dtr = dtr;
    e.pcs = pcs; e.lnk = lnk; e.dmc = dmc; e.wd = wd;
    return e;
  endfunction

  function automatic logic [31:0] outs();
    return 32'({mem_bus.imem_req, mem_bus.dmem_req, mem_bus.wren_data, ir_load,
                alu_control, alu_src, wren_reg, datamem_toreg, pc_en, pc_src, link});
  endfunction

  initial begin
    int hi;
    int target;
    int d0;

    // Reset state
    run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", outs(), 32'd0);
    chk("reset_retired", 32'(instr_retired), 32'd0);
    #2 rst_n = 1'b1;

    // Main function: directed instructions with hand-computed expectations
    do_instr(8'h10, 0, 0, 1'b0, mk(3'b001, 1'b0, 4, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b0)); // add
    do_instr(8'hA0, 0, 3, 1'b0, mk(3'b001, 1'b1, 8, 1'b1, 1'b1, 2'b00, 1'b0, 4, 1'b0)); // lw, 3 waits
    do_instr(8'hB5, 0, 0, 1'b0, mk(3'b001, 1'b1, 4, 1'b0, 1'b0, 2'b00, 1'b0, 1, 1'b1)); // sw
    do_instr(8'hC0, 0, 0, 1'b1, mk(3'b101, 1'b0, 3, 1'b0, 1'b0, 2'b10, 1'b0, 0, 1'b0)); // beq taken
    do_instr(8'hC0, 0, 0, 1'b0, mk(3'b101, 1'b0, 3, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0)); // beq not taken
    do_instr(8'hD0, 0, 0, 1'b0, mk(3'b101, 1'b0, 3, 1'b0, 1'b0, 2'b10, 1'b0, 0, 1'b0)); // bne taken
    do_instr(8'hD0, 0, 0, 1'b1, mk(3'b101, 1'b0, 3, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0)); // bne not taken
    do_instr(8'h83, 0, 0, 1'b0, mk(3'b000, 1'b0, 3, 1'b0, 1'b0, 2'b01, 1'b0, 0, 1'b0)); // j
    do_instr(8'h90, 0, 0, 1'b0, mk(3'b000, 1'b0, 3, 1'b1, 1'b0, 2'b01, 1'b1, 0, 1'b0)); // jal
    do_instr(8'h6F, 2, 0, 1'b0, mk(3'b110, 1'b1, 4, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b0)); // sll, imem waits
    do_instr(8'h41, 0, 0, 1'b0, mk(3'b100, 1'b0, 4, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b0)); // nor
    do_instr(8'h00, 0, 0, 1'b0, mk(3'b000, 1'b0, 4, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b0)); // move

    // run dropped mid-instruction: current add completes, then no fetch
    imem_wait = 0; dmem_wait = 0;
    target = loads + 1;
    sb.push_back(mk(3'b001, 1'b0, 4, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b0));
    iq.push_back(8'h12);
    for (int i = 0; i < 40 && loads < target; i++) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    wait_done(done + 1);
    exp_ret++;
    check_retired();
    sb.push_back(mk(3'b000, 1'b0, 3, 1'b0, 1'b0, 2'b01, 1'b0, 0, 1'b0));
    iq.push_back(8'h80);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (mem_bus.imem_req) hi++;
    end
    chk("idle_imem_req_cycles", 32'(hi), 32'd0);
    target = done + 1;
    run = 1'b1;
    wait_done(target);
    exp_ret++;
    check_retired();

    // Asynchronous reset while sw waits in MEM
    imem_wait = 0; dmem_wait = 20;
    iq.push_back(8'hB0);
    hi = 0;
    for (int i = 0; i < 30 && hi == 0; i++) begin
      @(negedge clk);
      #1;
      if (mem_bus.dmem_req) hi = 1;
    end
    chk("sw_reached_mem", 32'(hi), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 32'd0);
    chk("async_reset_retired", 32'(instr_retired), 32'd0);
    exp_ret = 0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("fetch_after_reset", 32'(mem_bus.imem_req), 32'd1);
    dmem_wait = 0;

    do_instr(8'h10, 0, 0, 1'b0, mk(3'b001, 1'b0, 4, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b0)); // add

    // Reserved opcode
`ifdef MCU_ILLEGAL_TRAP_EN
    d0 = done;
    iq.push_back(8'hF0);
    repeat (8) @(negedge clk);
    #1;
    chk("trap", 32'(trap), 32'd1);
    chk("trap_outputs", outs(), 32'd0);
    chk("trap_no_pc_en", 32'(done - d0), 32'd0);
    chk("trap_retired", 32'(instr_retired), 32'(exp_ret));
    repeat (4) @(negedge clk);
    #1;
    chk("trap_sticky", 32'(trap), 32'd1);
`else
    d0 = 0;
    do_instr(8'hF0, 0, 0, 1'b0, mk(3'b000, 1'b0, 3, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0));
    chk("nop_no_extra", 32'(d0), 32'd0);
`endif

    // Counter saturation at all-ones (2-bit instance)
    @(negedge clk);
    sat_inc = 1'b1;
    repeat (2) @(negedge clk);
    chk("sat_count_2", 32'(sat_count), 32'd2);
    repeat (3) @(negedge clk);
    chk("sat_count_hold", 32'(sat_count), 32'd3);
    sat_inc = 1'b0;

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
